// File: rtl/rgb_pwm_pkg.sv
// Shared mode encodings and elaboration helpers for the RGB PWM sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rgb_pwm_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int max1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: shadow/active config, breathe envelope, registered compare output.
// Latency: pwm_out follows pwm_cnt by one clock; config commits at the next period boundary.
// Backpressure: none; shadow accepts a write every cycle.
module rgb_pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int BREATHE_STEP = 1
) (
    input  logic                hw_clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                boundary,
    input  logic                blink_phase,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                wr_en,
    input  mode_e               wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    output logic                pwm_out
);

    typedef struct packed {
        mode_e               mode;
        logic [PWM_BITS-1:0] duty;
    } ch_cfg_t;

    localparam logic [PWM_BITS:0] STEP = (PWM_BITS+1)'(BREATHE_STEP);

    ch_cfg_t             shadow;
    ch_cfg_t             active;
    logic [PWM_BITS-1:0] level;
    logic                dir_down;

    logic [PWM_BITS:0]   duty_x;
    logic [PWM_BITS:0]   lvl_up;
    logic [PWM_BITS:0]   lvl_dn;
    logic [PWM_BITS-1:0] lvl_next;
    logic                dir_next;
    logic [PWM_BITS-1:0] eff;
    logic                full_on;

    // Envelope step uses the duty being committed, computed one bit wider so
    // neither direction can wrap.
    always_comb begin
        duty_x   = {1'b0, shadow.duty};
        lvl_up   = {1'b0, level} + STEP;
        lvl_dn   = ({1'b0, level} > STEP) ? ({1'b0, level} - STEP) : '0;
        lvl_next = level;
        dir_next = dir_down;
        if (!dir_down) begin
            lvl_next = (lvl_up > duty_x) ? shadow.duty : lvl_up[PWM_BITS-1:0];
            dir_next = (lvl_up >= duty_x);
        end else begin
            lvl_next = lvl_dn[PWM_BITS-1:0];
            dir_next = (lvl_dn != '0);
        end
    end

    always_comb begin
        eff     = '0;
        full_on = 1'b0;
        case (active.mode)
            MODE_OFF:     eff = '0;
            MODE_STATIC:  eff = active.duty;
            MODE_BLINK:   eff = blink_phase ? active.duty : '0;
            MODE_BREATHE: eff = level;
            default:      eff = '0;
        endcase
        // A counter compare can never reach 100%, so max duty is forced on.
        if ((active.mode == MODE_STATIC || (active.mode == MODE_BLINK && blink_phase))
            && active.duty == '1) begin
            full_on = 1'b1;
        end
    end

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '{mode: MODE_OFF, duty: '0};
            active   <= '{mode: MODE_OFF, duty: '0};
            level    <= '0;
            dir_down <= 1'b0;
            pwm_out  <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow <= '{mode: wr_mode, duty: wr_duty};
            end
            if (boundary) begin
                active <= shadow;
                if (shadow.mode == MODE_BREATHE) begin
                    if (active.mode != MODE_BREATHE) begin
                        level    <= '0;
                        dir_down <= 1'b0;
                    end else begin
                        level    <= lvl_next;
                        dir_down <= dir_next;
                    end
                end
            end
            pwm_out <= enable && (full_on || (pwm_cnt < eff));
        end
    end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// N-channel PWM pattern generator (OFF/STATIC/BLINK/BREATHE) for SB_RGBA_DRV RGBxPWM.
// Latency: pwm_out registered one clock after pwm_cnt; config commits at the next period wrap.
// Backpressure: cfg_ready high from the first clock after reset; every write is taken in one cycle.
module rgb_pwm_sequencer
    import rgb_pwm_pkg::*;
#(
    parameter  int NUM_CH        = 3,
    parameter  int PWM_BITS      = 8,
    parameter  int PRESCALE      = 48,
    parameter  int BLINK_PERIODS = 64,
    parameter  int BREATHE_STEP  = 1,
    localparam int CH_W          = max1(clog2(NUM_CH))
) (
    input  logic                hw_clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [MODE_W-1:0]   cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic                cfg_err,
    output logic                period_start,
    output logic [NUM_CH-1:0]   pwm_out
);

    localparam int PS_W = max1(clog2(PRESCALE));
    localparam int BK_W = max1(clog2(BLINK_PERIODS));
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [BK_W-1:0] BK_LAST = BK_W'(BLINK_PERIODS - 1);
    localparam logic [CH_W:0]   CH_LIM  = (CH_W+1)'(NUM_CH);

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("rgb_pwm_sequencer: NUM_CH must be 1..8");
    end
    if (PRESCALE < 1 || BLINK_PERIODS < 1) begin : g_bad_timebase
        $error("rgb_pwm_sequencer: PRESCALE and BLINK_PERIODS must be >= 1");
    end

    logic [PS_W-1:0]     presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BK_W-1:0]     blink_cnt;
    logic                blink_phase;
    logic                tick;
    logic                boundary;
    logic                cfg_fire;
    logic                ch_ok;
    logic [NUM_CH-1:0]   wr_en;

    assign tick     = enable && (presc == PS_LAST);
    assign boundary = tick && (pwm_cnt == '1);
    assign cfg_fire = cfg_valid && cfg_ready;
    assign ch_ok    = ({1'b0, cfg_ch} < CH_LIM);

    always_comb begin
        wr_en = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_en[c] = cfg_fire && ch_ok && (cfg_ch == CH_W'(c));
        end
    end

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
            cfg_err   <= cfg_fire && !ch_ok;
        end
    end

    // Timebase: everything holds while enable is low so re-enable resumes mid-period.
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            pwm_cnt      <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b1;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            if (enable) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (boundary) begin
                if (blink_cnt == BK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rgb_pwm_channel #(
            .PWM_BITS     (PWM_BITS),
            .BREATHE_STEP (BREATHE_STEP)
        ) u_ch (
            .hw_clk      (hw_clk),
            .rst_n       (rst_n),
            .enable      (enable),
            .boundary    (boundary),
            .blink_phase (blink_phase),
            .pwm_cnt     (pwm_cnt),
            .wr_en       (wr_en[c]),
            .wr_mode     (mode_e'(cfg_mode)),
            .wr_duty     (cfg_duty),
            .pwm_out     (pwm_out[c])
        );
    end

    a_ps_pulse: assert property (@(posedge hw_clk) disable iff (!rst_n)
        period_start |=> !period_start);
    a_err_cause: assert property (@(posedge hw_clk) disable iff (!rst_n)
        cfg_err |-> $past(cfg_valid && cfg_ready));
    a_off_disabled: assert property (@(posedge hw_clk) disable iff (!rst_n)
        !$past(enable) |-> (pwm_out == '0));

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Scoreboard bench: a period-level reference model predicts every clock's outputs into a queue.
module tb_rgb_pwm_sequencer;

    localparam int NCH  = 3;
    localparam int PB   = 4;
    localparam int PS   = 2;
    localparam int BP   = 2;
    localparam int STEP = 1;
    localparam int TOP  = (1 << PB) - 1;
    localparam int PER  = PS * (1 << PB);

    logic           hw_clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = '0;
    logic [1:0]     cfg_mode = '0;
    logic [PB-1:0]  cfg_duty = '0;
    logic           cfg_err;
    logic           period_start;
    logic [NCH-1:0] pwm_out;

    always #5 hw_clk = ~hw_clk;

    rgb_pwm_sequencer #(
        .NUM_CH        (NCH),
        .PWM_BITS      (PB),
        .PRESCALE      (PS),
        .BLINK_PERIODS (BP),
        .BREATHE_STEP  (STEP)
    ) dut (
        .hw_clk       (hw_clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_mode     (cfg_mode),
        .cfg_duty     (cfg_duty),
        .cfg_err      (cfg_err),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    typedef struct packed {
        logic [NCH-1:0] pwm;
        logic           ps;
        logic           err;
        logic           rdy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Model state: enabled clocks since reset, boundaries seen, per-channel configs,
    // and periods elapsed since each channel entered BREATHE.
    int m_en;
    int m_p;
    bit m_rdy;
    int sh_mode[NCH];
    int sh_duty[NCH];
    int ac_mode[NCH];
    int ac_duty[NCH];
    int bk[NCH];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    function automatic int tri_level(input int k, input int d);
        int pos;
        if (d == 0) return 0;
        pos = k % (2 * d);
        return (pos <= d) ? pos : 2 * d - pos;
    endfunction

    task automatic model_reset();
        m_en = 0;
        m_p = 0;
        m_rdy = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            sh_mode[c] = 0; sh_duty[c] = 0;
            ac_mode[c] = 0; ac_duty[c] = 0;
            bk[c] = 0;
        end
    endtask

    task automatic model_step();
        exp_t e;
        int   cnt;
        int   eff;
        bit   on;
        bit   bnd;
        bit   fire;
        bit   full;
        e = '0;
        if (!rst_n) begin
            model_reset();
            q.push_back(e);
            return;
        end
        cnt = (m_en / PS) % (1 << PB);
        on  = ((m_p / BP) % 2) == 0;
        bnd = enable && (m_en % PER == PER - 1);
        for (int c = 0; c < NCH; c++) begin
            case (ac_mode[c])
                1: eff = ac_duty[c];
                2: eff = on ? ac_duty[c] : 0;
                3: eff = tri_level(bk[c], ac_duty[c]);
                default: eff = 0;
            endcase
            full = (ac_mode[c] == 1 || (ac_mode[c] == 2 && on)) && ac_duty[c] == TOP;
            e.pwm[c] = enable && (full || cnt < eff);
        end
        fire  = cfg_valid && m_rdy;
        e.ps  = bnd;
        e.err = fire && (int'(cfg_ch) >= NCH);
        e.rdy = 1'b1;
        if (bnd) begin
            for (int c = 0; c < NCH; c++) begin
                if (sh_mode[c] == 3) bk[c] = (ac_mode[c] == 3) ? bk[c] + 1 : 0;
                ac_mode[c] = sh_mode[c];
                ac_duty[c] = sh_duty[c];
            end
            m_p++;
        end
        if (fire && int'(cfg_ch) < NCH) begin
            sh_mode[cfg_ch] = int'(cfg_mode);
            sh_duty[cfg_ch] = int'(cfg_duty);
        end
        if (enable) m_en++;
        m_rdy = 1'b1;
        q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge hw_clk);
            model_step();
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge hw_clk);
            #1;
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty: got no prediction at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("pwm_out", 32'(pwm_out), 32'(e.pwm));
                chk("period_start", 32'(period_start), 32'(e.ps));
                chk("cfg_err", 32'(cfg_err), 32'(e.err));
                chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge hw_clk);
    endtask

    task automatic wr(input int ch, input int mode, input int duty);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_mode  = 2'(mode);
        cfg_duty  = PB'(duty);
        @(negedge hw_clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int ch;
        int md;
        int dsel;
        int dv;
        int i;
        enable = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(70);
        idle(11);
        wr(0, 1, 4);
        idle(70);
        wr(0, 1, 15);
        idle(40);
        wr(1, 2, 8);
        idle(5 * PER);
        wr(2, 3, 3);
        idle(9 * PER);
        wr(3, 1, 9);
        idle(10);
        // Land a write exactly on the boundary clock.
        i = 0;
        while (!(m_en % PER == PER - 1) && i < 2 * PER) begin
            @(negedge hw_clk);
            i++;
        end
        if (!(m_en % PER == PER - 1)) begin
            n_checks++;
            $display("FAIL boundary_align: got no boundary within %0d clocks", 2 * PER);
        end
        wr(0, 1, 6);
        idle(70);
        idle(7);
        enable = 1'b0;
        idle(20);
        enable = 1'b1;
        idle(40);
        wr(0, 1, 15);
        idle(45);
        enable = 1'b0;
        idle(3);
        enable = 1'b1;
        idle(5);
        #2;
        chk("pre_reset_pwm0", 32'(pwm_out[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_pwm", 32'(pwm_out), 32'd0);
        chk("async_reset_ready", 32'(cfg_ready), 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(40);
        for (int n = 0; n < 3000; n++) begin
            cfg_valid = ($urandom_range(0, 7) == 0);
            ch = $urandom_range(0, 3);
            md = $urandom_range(0, 3);
            if (md == 3 && ch < NCH && (sh_mode[ch] == 3 || ac_mode[ch] == 3)) md = 1;
            dsel = $urandom_range(0, 3);
            dv = (dsel == 0) ? 0 : (dsel == 1) ? TOP : $urandom_range(0, TOP);
            cfg_ch   = 2'(ch);
            cfg_mode = 2'(md);
            cfg_duty = PB'(dv);
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            @(negedge hw_clk);
        end
        cfg_valid = 1'b0;
        enable = 1'b1;
        idle(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
